// File: rtl/powerup_pkg.sv
// Shared types and helpers for the power-up spawn scheduler.
package powerup_pkg;

    typedef enum logic [1:0] {S_IDLE, S_COOLDOWN, S_SPAWN, S_FALL} sched_state_t;
    typedef enum logic [1:0] {PU_RAPID, PU_SPREAD, PU_SHIELD, PU_SPEED} powerup_kind_t;

    typedef struct packed {
        logic [9:0]    startpos;
        powerup_kind_t kind;
    } spawn_req_t;

    localparam logic [15:0] LFSR_TAPS   = 16'hB400;
    // Frames after the spawn edge with no sighting before the request is written off.
    localparam int          LOST_FRAMES = 4;

    // Folds a 10-bit random draw into [min_x, min_x+x_range-1] with one conditional subtract.
    function automatic logic [9:0] spawn_x(input logic [9:0] r_raw,
                                           input logic [9:0] min_x,
                                           input logic [9:0] x_range);
        logic [9:0] r;
        r = r_raw;
        if (r >= x_range)
            r = r - x_range;
        return min_x + r;
    endfunction

endpackage

// File: rtl/lfsr16.sv
// 16-bit Galois LFSR advancing every frame; the seed must be nonzero.
module lfsr16
    import powerup_pkg::*;
#(
    parameter logic [15:0] SEED = 16'hACE1
) (
    input  logic        clk,
    input  logic        Reset_n,
    output logic [15:0] value
);

    always_ff @(posedge clk) begin
        if (!Reset_n)
            value <= SEED;
        else
            value <= {1'b0, value[15:1]} ^ (value[0] ? LFSR_TAPS : 16'h0000);
    end

endmodule

// File: rtl/powerup_scheduler.sv
// Decides when, where and which power-up drops, tracks its fall, and runs the effect timer.
module powerup_scheduler
    import powerup_pkg::*;
#(
    parameter int unsigned  COOLDOWN_FRAMES = 120,
    parameter logic [15:0]  JITTER_MASK     = 16'h3F,
    parameter int unsigned  EFFECT_FRAMES   = 600,
    parameter logic [9:0]   MIN_X           = 10'd16,
    parameter logic [9:0]   X_RANGE         = 10'd600,
    parameter logic [15:0]  LFSR_SEED       = 16'hACE1
) (
    input  logic       frame_clk,
    input  logic       Reset_n,
    input  logic       enable,
    input  logic       powerup_exists,
    input  logic       got_powerup,
    output logic       generate_powerup,
    output logic [9:0] powerup_startpos,
    output logic [1:0] pending_type,
    output logic       power_active,
    output logic [1:0] power_type,
    output logic [9:0] effect_frames_left
);

    sched_state_t state, state_nxt;
    logic [15:0]  lfsr;
    logic [15:0]  cooldown, cooldown_nxt, cooldown_load;
    logic         seen_exists, seen_nxt;
    logic [1:0]   fall_frames, fall_nxt;
    logic         fall_done;
    spawn_req_t   spawn_req;

    lfsr16 #(.SEED(LFSR_SEED)) u_lfsr (
        .clk     (frame_clk),
        .Reset_n (Reset_n),
        .value   (lfsr)
    );

    assign cooldown_load = 16'(COOLDOWN_FRAMES) + (lfsr & JITTER_MASK);

    assign spawn_req.startpos = spawn_x(lfsr[9:0], MIN_X, X_RANGE);
    assign spawn_req.kind     = powerup_kind_t'(lfsr[11:10]);

    // Catch, object gone after being seen, or never showed up in time.
    assign fall_done = got_powerup
                    || (seen_exists && !powerup_exists)
                    || (!seen_exists && !powerup_exists && fall_frames == 2'(LOST_FRAMES - 1));

    always_comb begin
        state_nxt    = state;
        cooldown_nxt = cooldown;
        seen_nxt     = seen_exists;
        fall_nxt     = fall_frames;
        if (!enable) begin
            state_nxt = S_IDLE;
        end else begin
            unique case (state)
                S_IDLE: begin
                    cooldown_nxt = cooldown_load;
                    state_nxt    = S_COOLDOWN;
                end
                S_COOLDOWN: begin
                    if (cooldown != 16'd0)
                        cooldown_nxt = cooldown - 16'd1;
                    else if (!powerup_exists)
                        state_nxt = S_SPAWN;
                end
                S_SPAWN: begin
                    seen_nxt  = 1'b0;
                    fall_nxt  = 2'd1;
                    state_nxt = S_FALL;
                end
                S_FALL: begin
                    if (fall_done) begin
                        cooldown_nxt = cooldown_load;
                        state_nxt    = S_COOLDOWN;
                    end else begin
                        if (powerup_exists)
                            seen_nxt = 1'b1;
                        if (fall_frames != 2'd3)
                            fall_nxt = fall_frames + 2'd1;
                    end
                end
                default: state_nxt = S_IDLE;
            endcase
        end
    end

    always_ff @(posedge frame_clk) begin
        if (!Reset_n) begin
            state            <= S_IDLE;
            cooldown         <= 16'd0;
            seen_exists      <= 1'b0;
            fall_frames      <= 2'd0;
            generate_powerup <= 1'b0;
            powerup_startpos <= MIN_X;
            pending_type     <= 2'd0;
        end else begin
            state            <= state_nxt;
            cooldown         <= cooldown_nxt;
            seen_exists      <= seen_nxt;
            fall_frames      <= fall_nxt;
            generate_powerup <= (state_nxt == S_SPAWN);
            if (state_nxt == S_SPAWN) begin
                powerup_startpos <= spawn_req.startpos;
                pending_type     <= spawn_req.kind;
            end
        end
    end

    // Effect timer ignores enable and the spawn FSM; a catch always (re)starts it.
    always_ff @(posedge frame_clk) begin
        if (!Reset_n) begin
            power_active       <= 1'b0;
            power_type         <= 2'd0;
            effect_frames_left <= 10'd0;
        end else if (got_powerup) begin
            power_active       <= 1'b1;
            power_type         <= pending_type;
            effect_frames_left <= 10'(EFFECT_FRAMES);
        end else if (power_active) begin
            if (effect_frames_left <= 10'd1) begin
                effect_frames_left <= 10'd0;
                power_active       <= 1'b0;
            end else begin
                effect_frames_left <= effect_frames_left - 10'd1;
            end
        end
    end

endmodule

// File: tb/tb_powerup_scheduler.sv
// Scoreboard bench: a timestamp-based reference model predicts every frame and every spawn.
module tb_powerup_scheduler;

    localparam int C    = 120;
    localparam int M    = 63;
    localparam int EF   = 600;
    localparam int MINX = 16;
    localparam int XR   = 600;
    localparam int SEED = 'hACE1;

    localparam int P_IDLE = 0;
    localparam int P_WAIT = 1;
    localparam int P_FALL = 2;

    logic       frame_clk = 1'b0;
    logic       Reset_n, enable, powerup_exists, got_powerup;
    logic       generate_powerup, power_active;
    logic [9:0] powerup_startpos, effect_frames_left;
    logic [1:0] pending_type, power_type;

    always #5 frame_clk = ~frame_clk;

    powerup_scheduler dut (
        .frame_clk          (frame_clk),
        .Reset_n            (Reset_n),
        .enable             (enable),
        .powerup_exists     (powerup_exists),
        .got_powerup        (got_powerup),
        .generate_powerup   (generate_powerup),
        .powerup_startpos   (powerup_startpos),
        .pending_type       (pending_type),
        .power_active       (power_active),
        .power_type         (power_type),
        .effect_frames_left (effect_frames_left)
    );

    typedef struct {
        int e; int gen; int sp; int pt; int act; int ety; int left;
    } frame_exp_t;
    typedef struct {
        int e; int sp; int pt;
    } spawn_exp_t;

    frame_exp_t fq[$];
    spawn_exp_t sq[$];
    int n_checks = 0;
    int n_pass   = 0;
    int edge_no  = 0;

    // Reference model: spawn and effect deadlines expressed as absolute edge numbers.
    int m_lfsr = SEED;
    int phase = P_IDLE;
    int spawn_at = 0, s_edge = -100;
    bit seen = 0, m_gen = 0;
    int m_sp = MINX, m_pt = 0;
    int eff_end = 0, eff_type = 0;

    // Behaviour of the falling object, driven on behalf of power_up.
    int obj_from = -1, obj_to = -2;
    bit obj_catch = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s at edge %0d: got %0d expected %0d", name, edge_no, act, exp);
    endtask

    function automatic int lfsr_next(input int v);
        return (v >> 1) ^ (((v & 1) != 0) ? 'hB400 : 0);
    endfunction

    function automatic bit obj_ex(input int e);
        return (e >= obj_from) && (e <= obj_to);
    endfunction

    function automatic bit obj_got(input int e);
        return obj_catch && (e == obj_to);
    endfunction

    task automatic plan(input int d, input int len, input bit c);
        obj_from  = s_edge + d;
        obj_to    = obj_from + len - 1;
        obj_catch = c;
    endtask

    task automatic step(input bit rst, input bit en, input bit ex, input bit gt);
        int e, v, r;
        frame_exp_t fx;
        Reset_n        = !rst;
        enable         = en;
        powerup_exists = ex;
        got_powerup    = gt;
        e = edge_no + 1;
        v = m_lfsr;
        m_gen = 0;
        if (rst) begin
            phase = P_IDLE; m_sp = MINX; m_pt = 0;
            eff_end = e; eff_type = 0; m_lfsr = SEED;
        end else begin
            if (gt) begin
                eff_end  = e + EF;
                eff_type = m_pt;
            end
            if (!en) phase = P_IDLE;
            else begin
                case (phase)
                    P_IDLE: begin
                        spawn_at = e + C + (v & M) + 1;
                        phase = P_WAIT;
                    end
                    P_WAIT: if (e >= spawn_at && !ex) begin
                        m_gen = 1; s_edge = e; seen = 0;
                        r = v % 1024;
                        if (r >= XR) r = r - XR;
                        m_sp = MINX + r;
                        m_pt = (v >> 10) % 4;
                        phase = P_FALL;
                    end
                    default: if (e > s_edge + 1) begin
                        if (gt || (seen && !ex) || (!seen && !ex && e >= s_edge + 4)) begin
                            spawn_at = e + C + (v & M) + 1;
                            phase = P_WAIT;
                        end else if (ex) seen = 1;
                    end
                endcase
            end
            m_lfsr = lfsr_next(v);
        end
        @(posedge frame_clk);
        edge_no++;
        fx.e = e; fx.gen = int'(m_gen); fx.sp = m_sp; fx.pt = m_pt;
        fx.act = (eff_end > e) ? 1 : 0;
        fx.ety = eff_type;
        fx.left = (eff_end > e) ? eff_end - e : 0;
        fq.push_back(fx);
        if (m_gen) begin
            spawn_exp_t sx;
            sx.e = e; sx.sp = m_sp; sx.pt = m_pt;
            sq.push_back(sx);
        end
        #1;
    endtask

    task automatic run(input int n, input bit en, input bit stop_on_spawn);
        for (int i = 0; i < n; i++) begin
            step(1'b0, en, obj_ex(edge_no + 1), obj_got(edge_no + 1));
            if (m_gen && stop_on_spawn) break;
        end
    endtask

    // Monitor: per-frame outputs, plus spawn pulses matched against the spawn queue.
    initial begin
        frame_exp_t fx;
        spawn_exp_t sx;
        forever begin
            @(negedge frame_clk);
            if (fq.size() > 0) begin
                fx = fq.pop_front();
                check("generate_powerup",   32'(generate_powerup),   32'(fx.gen));
                check("powerup_startpos",   32'(powerup_startpos),   32'(fx.sp));
                check("pending_type",       32'(pending_type),       32'(fx.pt));
                check("power_active",       32'(power_active),       32'(fx.act));
                check("power_type",         32'(power_type),         32'(fx.ety));
                check("effect_frames_left", 32'(effect_frames_left), 32'(fx.left));
            end
            if (generate_powerup === 1'b1) begin
                check("spawn_expected", 32'(sq.size() > 0), 32'd1);
                if (sq.size() > 0) begin
                    sx = sq.pop_front();
                    check("spawn_edge",     32'(edge_no),          32'(sx.e));
                    check("spawn_startpos", 32'(powerup_startpos), 32'(sx.sp));
                    check("spawn_type",     32'(pending_type),     32'(sx.pt));
                end
            end
        end
    end

    initial begin
        int g;
        bit en_r;
        bit rst, gt;
        int d, len, pick;

        step(1'b1, 1'b0, 1'b0, 1'b0);
        step(1'b1, 1'b0, 1'b0, 1'b0);

        // First spawn, then an object that lingers 200 frames and is never caught.
        run(400, 1'b1, 1'b1);
        plan(2, 200, 1'b0);
        run(600, 1'b1, 1'b1);

        // Caught quickly, then the next one caught with five effect frames left.
        plan(2, 10, 1'b1);
        g = obj_to;
        run(30, 1'b1, 1'b0);
        run(400, 1'b1, 1'b1);
        obj_from  = s_edge + 2;
        obj_to    = g + 596;
        obj_catch = 1'b1;
        run(g + 596 - edge_no, 1'b1, 1'b0);
        run(1300, 1'b0, 1'b0);

        // Effect running, object falling, then reset and a disabled stretch.
        step(1'b0, 1'b1, 1'b0, 1'b1);
        run(400, 1'b1, 1'b1);
        plan(2, 50, 1'b0);
        run(10, 1'b1, 1'b0);
        step(1'b1, 1'b1, obj_ex(edge_no + 1), 1'b0);
        step(1'b1, 1'b0, obj_ex(edge_no + 1), 1'b0);
        run(300, 1'b0, 1'b0);

        en_r = 1'b1;
        for (int i = 0; i < 20000; i++) begin
            rst = ($urandom_range(0, 999) == 0);
            if ($urandom_range(0, 399) == 0) en_r = !en_r;
            gt = obj_got(edge_no + 1) || ($urandom_range(0, 499) == 0);
            step(rst, en_r, obj_ex(edge_no + 1), gt);
            if (m_gen) begin
                d = int'($urandom_range(1, 6));
                pick = int'($urandom_range(0, 9));
                len = (pick < 5) ? int'($urandom_range(1, 20)) :
                      (pick < 9) ? int'($urandom_range(20, 60)) : 200;
                plan(d, len, bit'($urandom_range(0, 1)));
            end
        end

        repeat (2) @(negedge frame_clk);
        #1;
        check("frame_queue_drained", 32'(fq.size()), 32'd0);
        check("spawn_queue_drained", 32'(sq.size()), 32'd0);
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
